// File: rtl/progress_tracker.sv
// Segmented progress bar driven by pass events, with optional fail penalty.
// Define FAIL_PENALTY_EN to make fail_i step the bar back by one segment.
module progress_tracker #(
  parameter int SEGMENTS = 16,
  parameter int CNT_W    = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear_i,
  input  logic                             pass_i,
  input  logic                             fail_i,
  input  logic [CNT_W-1:0]                 passes_per_seg,
  output logic [SEGMENTS-1:0]              progress_o,
  output logic [$clog2(SEGMENTS+1)-1:0]    level_o,
  output logic                             finished_o,
  output logic                             finished_pulse_o
);

  localparam int LW = $clog2(SEGMENTS+1);
  localparam logic [LW-1:0] FULL = LW'(SEGMENTS);
  localparam logic [LW-1:0] L1 = LW'(1);
  localparam logic [CNT_W:0] ONE_W = (CNT_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     level_q, level_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic [CNT_W-1:0]  thr;
  logic              hit;
  logic              fail_act;

  assign thr = (passes_per_seg == '0) ? CNT_W'(1) : passes_per_seg;

  // Extra bit keeps counter+1 from wrapping when the threshold drops.
  assign hit = ({1'b0, cnt_q} + ONE_W) >= {1'b0, thr};

`ifdef FAIL_PENALTY_EN
  assign fail_act = fail_i;
`else
  logic unused_fail;
  assign unused_fail = fail_i;
  assign fail_act    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      level_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE, RUN: begin
          if (fail_act) begin
            cnt_d = '0;
            if (level_q > L1) begin
              level_d = level_q - L1;
              state_d = RUN;
            end else begin
              level_d = '0;
              state_d = IDLE;
            end
          end else if (pass_i) begin
            state_d = RUN;
            if (hit) begin
              cnt_d   = '0;
              level_d = level_q + L1;
              if (level_q == FULL - L1) begin
                state_d = DONE;
                pulse_d = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          cnt_d   = '0;
          level_d = FULL;
        end
        default: begin
          state_d = IDLE;
          level_d = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  for (genvar i = 0; i < SEGMENTS; i++) begin : g_bar
    assign progress_o[i] = (level_q > LW'(i));
  end

  assign level_o          = level_q;
  assign finished_o       = (state_q == DONE);
  assign finished_pulse_o = pulse_q;

endmodule

// File: tb/tb_progress_tracker.sv
// Randomized self-checking bench for progress_tracker.
// Expected values come from an integer model of level and pass count.
module tb_progress_tracker;

  localparam int SEG = 16;
  localparam int CW  = 3;
  localparam int LW  = $clog2(SEG+1);

`ifdef FAIL_PENALTY_EN
  localparam bit FAIL_EN = 1'b1;
`else
  localparam bit FAIL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            clear_i = 1'b0;
  logic            pass_i = 1'b0;
  logic            fail_i = 1'b0;
  logic [CW-1:0]   passes_per_seg = '0;
  logic [SEG-1:0]  progress_o;
  logic [LW-1:0]   level_o;
  logic            finished_o;
  logic            finished_pulse_o;

  int checks = 0;
  int failures = 0;

  int m_level = 0;
  int m_cnt = 0;
  bit m_pulse = 1'b0;

  progress_tracker #(.SEGMENTS(SEG), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .clear_i          (clear_i),
    .pass_i           (pass_i),
    .fail_i           (fail_i),
    .passes_per_seg   (passes_per_seg),
    .progress_o       (progress_o),
    .level_o          (level_o),
    .finished_o       (finished_o),
    .finished_pulse_o (finished_pulse_o)
  );

  always #5 clk = ~clk;

  function automatic logic [SEG-1:0] bar(input int lvl);
    logic [SEG:0] b;
    b = (SEG+1)'(1) << lvl;
    return SEG'(b - (SEG+1)'(1));
  endfunction

  // One clock with the given inputs; the model advances in lockstep.
  task automatic step(input bit p, input bit f, input bit c, input int pps);
    int thr;
    bit was_done;
    pass_i = p;
    fail_i = f;
    clear_i = c;
    passes_per_seg = CW'(pps);
    @(posedge clk);
    thr = (pps == 0) ? 1 : pps;
    was_done = (m_level == SEG);
    if (c) begin
      m_level = 0;
      m_cnt = 0;
    end else if (!was_done && FAIL_EN && f) begin
      m_cnt = 0;
      if (m_level > 0) m_level--;
    end else if (!was_done && p) begin
      if (m_cnt + 1 >= thr) begin
        m_level++;
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    m_pulse = !c && !was_done && (m_level == SEG);
    #1;
    pass_i = 1'b0;
    fail_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks += 4;
    if (level_o !== '0) begin
      failures++;
      $display("FAIL reset_level got=%0d exp=0", level_o);
    end
    if (progress_o !== '0) begin
      failures++;
      $display("FAIL reset_bar got=%h exp=0", progress_o);
    end
    if (finished_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_fin got=%b exp=0", finished_o);
    end
    if (finished_pulse_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulse got=%b exp=0", finished_pulse_o);
    end
    @(negedge clk);
    reset = 1'b0;
    m_level = 0;
    m_cnt = 0;
  endtask

  task automatic test_three_passes();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 3);
      step(0, 0, 0, 3);
    end
    checks += 2;
    if (level_o !== LW'(1)) begin
      failures++;
      $display("FAIL thr3_level got=%0d exp=1", level_o);
    end
    if (progress_o !== 16'h0001) begin
      failures++;
      $display("FAIL thr3_bar got=%h exp=0001", progress_o);
    end
  endtask

  task automatic test_fill();
    int pulses = 0;
    step(0, 0, 1, 1);
    for (int i = 0; i < SEG; i++) begin
      step(1, 0, 0, 1);
      pulses += int'(finished_pulse_o);
      checks++;
      if (level_o !== LW'(i + 1)) begin
        failures++;
        $display("FAIL fill_level i=%0d got=%0d exp=%0d", i, level_o, i + 1);
      end
    end
    step(1, 0, 0, 1);
    pulses += int'(finished_pulse_o);
    checks += 5;
    if (progress_o !== 16'hFFFF) begin
      failures++;
      $display("FAIL fill_bar got=%h exp=ffff", progress_o);
    end
    if (finished_o !== 1'b1) begin
      failures++;
      $display("FAIL fill_fin got=%b exp=1", finished_o);
    end
    if (pulses != 1) begin
      failures++;
      $display("FAIL fill_pulse_count got=%0d exp=1", pulses);
    end
    if (level_o !== LW'(SEG)) begin
      failures++;
      $display("FAIL fill_sat got=%0d exp=%0d", level_o, SEG);
    end
    if (finished_pulse_o !== 1'b0) begin
      failures++;
      $display("FAIL fill_pulse_stuck got=%b exp=0", finished_pulse_o);
    end
  endtask

  task automatic test_zero_thr();
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++;
    if (level_o !== LW'(2)) begin
      failures++;
      $display("FAIL thr0_level got=%0d exp=2", level_o);
    end
  endtask

  task automatic test_lower_thr();
    step(0, 0, 1, 5);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 5);
    step(1, 0, 0, 2);
    checks++;
    if (level_o !== LW'(1)) begin
      failures++;
      $display("FAIL lower_level got=%0d exp=1", level_o);
    end
    // Counter must have restarted: one pass at threshold 2 is not enough.
    step(1, 0, 0, 2);
    checks++;
    if (level_o !== LW'(1)) begin
      failures++;
      $display("FAIL lower_cnt got=%0d exp=1", level_o);
    end
    step(1, 0, 0, 2);
    checks++;
    if (level_o !== LW'(2)) begin
      failures++;
      $display("FAIL lower_next got=%0d exp=2", level_o);
    end
  endtask

  task automatic test_clear_and_reset();
    step(0, 0, 1, 2);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 2);
    checks++;
    if (level_o !== LW'(7)) begin
      failures++;
      $display("FAIL l7_setup got=%0d exp=7", level_o);
    end
    step(1, 1, 1, 2);
    checks += 2;
    if (level_o !== '0) begin
      failures++;
      $display("FAIL clr_level got=%0d exp=0", level_o);
    end
    if (progress_o !== '0) begin
      failures++;
      $display("FAIL clr_bar got=%h exp=0", progress_o);
    end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    checks += 3;
    if (level_o !== '0) begin
      failures++;
      $display("FAIL async_level got=%0d exp=0", level_o);
    end
    if (progress_o !== '0) begin
      failures++;
      $display("FAIL async_bar got=%h exp=0", progress_o);
    end
    if (finished_o !== 1'b0 || finished_pulse_o !== 1'b0) begin
      failures++;
      $display("FAIL async_fin got=%b%b exp=00", finished_o, finished_pulse_o);
    end
    @(negedge clk);
    reset = 1'b0;
    m_level = 0;
    m_cnt = 0;
    step(1, 0, 0, 1);
    checks++;
    if (level_o !== LW'(1)) begin
      failures++;
      $display("FAIL post_reset got=%0d exp=1", level_o);
    end
  endtask

  task automatic test_fail();
    logic [LW-1:0] exp;
    step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    step(1, 1, 0, 1);
    exp = FAIL_EN ? LW'(2) : LW'(4);
    checks++;
    if (level_o !== exp) begin
      failures++;
      $display("FAIL fail_beats_pass got=%0d exp=%0d", level_o, exp);
    end
    step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    checks++;
    if (level_o !== '0) begin
      failures++;
      $display("FAIL fail_at_zero got=%0d exp=0", level_o);
    end
  endtask

  task automatic test_random();
    bit p, f, c;
    int pps;
    step(0, 0, 1, 1);
    for (int n = 0; n < 800; n++) begin
      p = ($urandom_range(99) < 70);
      f = ($urandom_range(99) < 10);
      c = ($urandom_range(99) < 2);
      pps = $urandom_range(7);
      step(p, f, c, pps);
      checks += 4;
      if (level_o !== LW'(m_level)) begin
        failures++;
        $display("FAIL rnd_level n=%0d got=%0d exp=%0d", n, level_o, m_level);
      end
      if (progress_o !== bar(m_level)) begin
        failures++;
        $display("FAIL rnd_bar n=%0d got=%h exp=%h", n, progress_o,
                 bar(m_level));
      end
      if (finished_o !== (m_level == SEG)) begin
        failures++;
        $display("FAIL rnd_fin n=%0d got=%b exp=%b", n, finished_o,
                 m_level == SEG);
      end
      if (finished_pulse_o !== m_pulse) begin
        failures++;
        $display("FAIL rnd_pulse n=%0d got=%b exp=%b", n,
                 finished_pulse_o, m_pulse);
      end
    end
  endtask

  initial begin
    test_reset();
    test_three_passes();
    test_fill();
    test_zero_thr();
    test_lower_thr();
    test_clear_and_reset();
    test_fail();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/progress_tracker.md
PROGRESS_TRACKER -- requirements
Module: progress_tracker

Interface
REQ-001 The block SHALL have parameter SEGMENTS, default 16, number of progress-bar segments (legal 2..64).
REQ-002 The block SHALL have parameter CNT_W, default 3, width of the passes-per-segment threshold and pass counter.
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port clear_i  input  1  synchronous restart of progress to empty.
REQ-006 The block SHALL have port pass_i  input  1  one pass event per cycle it is high.
REQ-007 The block SHALL have port fail_i  input  1  one fail event per cycle it is high (ignored unless FAIL_PENALTY_EN).
REQ-008 The block SHALL have port passes_per_seg  input  CNT_W  passes required to fill one segment.
REQ-009 The block SHALL have port progress_o  output  SEGMENTS  thermometer bar; bit i high iff i < level.
REQ-010 The block SHALL have port level_o  output  $clog2(SEGMENTS+1)  filled-segment count.
REQ-011 The block SHALL have port finished_o  output  1  sticky; high while level == SEGMENTS.
REQ-012 The block SHALL have port finished_pulse_o  output  1  one-cycle pulse on entering finished.

Function
REQ-013 The block SHALL hold an internal pass counter (CNT_W bits) and level register; all outputs SHALL be registered or pure decode of these registers.
REQ-014 Effective threshold SHALL be passes_per_seg, with value 0 treated as 1; sampled every cycle, no latching.
REQ-015 On a cycle with pass_i high, not finished: if counter+1 >= threshold, level SHALL increment and counter SHALL clear; else counter SHALL increment.
REQ-016 Latency: level_o/progress_o SHALL reflect a pass on the first rising edge at which it is sampled (visible the following cycle).
REQ-017 Threshold lowered mid-segment below current counter+1: the next pass SHALL advance the level (>= compare, no wrap).
REQ-018 Level SHALL saturate at SEGMENTS; passes while finished SHALL be ignored and counter SHALL stay 0.
REQ-019 The block SHALL be a three-state FSM: IDLE (level 0, counter 0), RUN (progress in flight), DONE (level == SEGMENTS); IDLE->RUN on first pass, RUN->DONE on final advance, any->IDLE on clear_i.
REQ-020 finished_pulse_o SHALL be high exactly the one cycle after the RUN->DONE transition edge (coincident with first finished_o high cycle).
REQ-021 clear_i SHALL have priority over pass_i and fail_i in the same cycle: level, counter to 0, state IDLE, finished_pulse_o low.
REQ-022 progress_o SHALL be a strict thermometer (no gaps) in every cycle.

Reset
REQ-023 While reset is high: level 0, counter 0, state IDLE, progress_o all 0, level_o 0, finished_o 0, finished_pulse_o 0.
REQ-024 Reset asserted mid-operation SHALL take effect immediately, independent of clk; first pass after deassertion SHALL count normally.

Configuration
REQ-025 With macro FAIL_PENALTY_EN defined, fail_i high in RUN SHALL clear the counter and decrement level by 1 (saturating at 0; level 0 -> IDLE).
REQ-026 With FAIL_PENALTY_EN, fail_i SHALL beat pass_i in the same cycle (pass discarded) and SHALL be ignored in DONE.
REQ-027 Without FAIL_PENALTY_EN, fail_i SHALL be ignored entirely and behaviour SHALL equal REQ-013..REQ-022.

Verification
REQ-028 SEGMENTS=16, passes_per_seg=3, 3 single pass pulses -> level_o=1, progress_o=16'h0001 after 3rd pulse.
REQ-029 passes_per_seg=1, 16 consecutive pass cycles -> progress_o=16'hFFFF, finished_o=1, finished_pulse_o high exactly 1 cycle; 17th pass -> no change.
REQ-030 passes_per_seg=0, 2 passes -> level_o=2 (0 treated as 1).
REQ-031 passes_per_seg=5, 4 passes, then passes_per_seg=2, 1 pass -> level_o=1, counter 0.
REQ-032 Level 7 mid-segment, clear_i and pass_i same cycle -> level_o=0, progress_o=0; async reset pulse between edges -> all outputs 0 immediately.
REQ-033 FAIL_PENALTY_EN, level 3, pass_i and fail_i same cycle -> level_o=2; at level 0 fail -> level_o stays 0; without macro -> level_o=4.
